// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a bank of seven-segment digits. A packed hex
//   word (plus per-digit decimal points and blank flags) is captured into
//   shadow registers on load, and one digit is driven per prescaler slot on
//   a shared segment bus with a one-hot digit enable. Every slot change
//   starts with one all-off cycle so the previous digit's segments never
//   ghost onto the next one.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous, active-high reset
//   data       : hex nibbles, nibble i (bits 4i+3:4i) is digit i, digit 0 rightmost
//   dp_in      : decimal point request per digit
//   blank_mask : 1 = force that digit dark
//   lz_blank   : 1 = suppress leading zeros (sampled live, not shadowed)
//   load       : capture data/dp_in/blank_mask into the shadow registers
//   HEX        : segments {a,b,c,d,e,f,g,dp}, a at MSB, after polarity
//   AN         : one-hot digit enable, after polarity
//   scan_idx   : index of the digit currently driven
//
// Interface timing: there is no valid/ready handshake. load is a one-cycle
// strobe with no back-pressure; the shadow registers update at the edge it
// is seen and the active digit reflects it one edge later.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int DIV_COE        = 25000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0,
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CNTW = $clog2(DIV_COE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic [7:0]            HEX,
  output logic [DIGITS-1:0]     AN,
  output logic [IDXW-1:0]       scan_idx
);

  logic [CNTW-1:0]     cnt;
  logic                tick;
  logic [IDXW-1:0]     idx;
  logic [4*DIGITS-1:0] data_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [DIGITS-1:0]   blank_sh;
  logic [DIGITS-1:0]   lz_supp;
  logic [3:0]          nib;
  logic [7:0]          seg_sel;
  logic [DIGITS-1:0]   an_sel;
  logic [7:0]          hex_r;
  logic [DIGITS-1:0]   an_r;
  logic [IDXW-1:0]     scan_r;

  // abcdefg in [7:1], dp slot [0] left clear
  function automatic logic [7:0] decode(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'b11111100;
      4'h1: s = 8'b01100000;
      4'h2: s = 8'b11011010;
      4'h3: s = 8'b11110010;
      4'h4: s = 8'b01100110;
      4'h5: s = 8'b10110110;
      4'h6: s = 8'b10111110;
      4'h7: s = 8'b11100000;
      4'h8: s = 8'b11111110;
      4'h9: s = 8'b11110110;
      4'hA: s = 8'b11101110;
      4'hB: s = 8'b00111110;
      4'hC: s = 8'b10011100;
      4'hD: s = 8'b01111010;
      4'hE: s = 8'b10011110;
      default: s = 8'b10001110;
    endcase
    return s;
  endfunction

  assign tick = (cnt == CNTW'(DIV_COE - 1));

  // Slot prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDXW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // Shadow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sh  <= '0;
      dp_sh    <= '0;
      blank_sh <= '0;
    end else if (load) begin
      data_sh  <= data;
      dp_sh    <= dp_in;
      blank_sh <= blank_mask;
    end
  end

  // Walk from the most significant digit down; a digit is a leading zero
  // while nothing at or above it is non-zero. Digit 0 is never suppressed.
  always_comb begin : p_lz
    logic upper_nz;
    upper_nz = 1'b0;
    lz_supp  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_nz = upper_nz | (data_sh[4*i +: 4] != 4'h0);
      if (i > 0) begin
        lz_supp[i] = lz_blank & ~upper_nz;
      end
    end
  end

  // Segment pattern and enable for the current index
  always_comb begin
    nib    = data_sh[4*int'(idx) +: 4];
    an_sel = DIGITS'(1) << idx;
    if (blank_sh[idx] | lz_supp[idx]) begin
      seg_sel = 8'h00;
    end else begin
      seg_sel = decode(nib) | {7'b0, dp_sh[idx]};
    end
  end

  // Output registers; the tick edge loads the all-off dead cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_r  <= '0;
      an_r   <= '0;
      scan_r <= '0;
    end else if (tick) begin
      hex_r  <= '0;
      an_r   <= '0;
    end else begin
      hex_r  <= seg_sel;
      an_r   <= an_sel;
      scan_r <= idx;
    end
  end

  assign HEX      = SEG_ACTIVE_LOW ? ~hex_r : hex_r;
  assign AN       = AN_ACTIVE_LOW  ? ~an_r  : an_r;
  assign scan_idx = scan_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] data       = '0;
  logic [3:0]  dp_in      = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_blank   = 1'b0;
  logic        load       = 1'b0;
  logic [7:0]  hex, hex_i;
  logic [3:0]  an, an_i;
  logic [1:0]  scan_idx, scan_i;

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV_COE(DIV), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank_mask(blank_mask),
    .lz_blank(lz_blank), .load(load), .HEX(hex), .AN(an), .scan_idx(scan_idx)
  );

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV_COE(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank_mask(blank_mask),
    .lz_blank(lz_blank), .load(load), .HEX(hex_i), .AN(an_i), .scan_idx(scan_i)
  );

  // Edges since reset release: the slot schedule is known from this alone
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [13:0] exp_q[$];   // {an[3:0], idx[1:0], hex[7:0]}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [3:0]  prev_an = '0;
  int          act_len = 0;
  int          off_len = 0;
  bit          seen_active = 1'b0;
  logic [13:0] e;
  logic [7:0]  inv_hex;
  logic [3:0]  inv_an;

  always @(negedge clk) begin
    if (rst) begin
      prev_an     = '0;
      act_len     = 0;
      off_len     = 0;
      seen_active = 1'b0;
    end else begin
      check("an_onehot0", 32'($onehot0(an)), 32'd1);
      if (an != 4'b0) begin
        if (prev_an == 4'b0) begin
          if (seen_active) check("dead_len", off_len, 1);
          if (exp_q.size() > 0) begin
            e       = exp_q.pop_front();
            inv_hex = ~e[7:0];
            inv_an  = ~e[13:10];
            check("slot_an",  an,       e[13:10]);
            check("slot_idx", scan_idx, e[9:8]);
            check("slot_hex", hex,      e[7:0]);
            check("inv_hex",  hex_i,    inv_hex);
            check("inv_an",   an_i,     inv_an);
          end
          act_len = 1;
        end else begin
          check("no_dead_between", an, prev_an);
          act_len++;
        end
        off_len = 0;
      end else begin
        if (prev_an != 4'b0) begin
          check("slot_len", act_len, DIV - 1);
          seen_active = 1'b1;
        end
        off_len++;
      end
      prev_an = an;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_phase(input int p);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (cyc % 4 == p) break;
    end
  endtask

  // Next slot index is known from the edge count at a dead-cycle negedge
  task automatic push_slots(input logic [31:0] exp_hex);
    int base;
    int k;
    base = (cyc / 4) % 4;
    for (int j = 0; j < 4; j++) begin
      k = (base + j) % 4;
      exp_q.push_back({4'(1 << k), 2'(k), exp_hex[8*k +: 8]});
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_drain_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic run_test(input string name, input logic [15:0] d, input logic [3:0] dp,
                          input logic [3:0] bl, input logic lz, input logic [31:0] exp_hex);
    wait_phase(1);
    data = d; dp_in = dp; blank_mask = bl; lz_blank = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_phase(0);
    push_slots(exp_hex);
    drain(name);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_hex"},     hex,      8'h00);
    check({name, "_an"},      an,       4'h0);
    check({name, "_idx"},     scan_idx, 2'd0);
    check({name, "_inv_hex"}, hex_i,    8'hFF);
    check({name, "_inv_an"},  an_i,     4'hF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    #1;
    check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // digit order {d3,d2,d1,d0}, patterns hand-decoded from the segment table
    run_test("hex_12af",   16'h12AF, 4'b0000, 4'b0000, 1'b0, 32'h60DA_EE8E);
    run_test("lz_0050",    16'h0050, 4'b0000, 4'b0000, 1'b1, 32'h0000_B6FC);
    run_test("nolz_0050",  16'h0050, 4'b0000, 4'b0000, 1'b0, 32'hFCFC_B6FC);
    run_test("lz_0f00",    16'h0F00, 4'b0000, 4'b0000, 1'b1, 32'h008E_FCFC);
    run_test("lz_zero",    16'h0000, 4'b0000, 4'b0000, 1'b1, 32'h0000_00FC);
    run_test("dp_blank",   16'h8888, 4'b0100, 4'b1000, 1'b0, 32'h00FF_FEFE);

    // load on the tick cycle: the slot after the dead cycle uses new shadow
    wait_phase(3);
    data = 16'h3456; dp_in = '0; blank_mask = '0; lz_blank = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push_slots(32'hF266_B6BE);
    drain("tick_load");

    // asynchronous reset in the middle of the idx=2 slot
    run_test("hex_12af_b", 16'h12AF, 4'b0000, 4'b0000, 1'b0, 32'h60DA_EE8E);
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (cyc % 4 == 2 && (cyc / 4) % 4 == 2) begin
        found = 1'b1;
        break;
      end
    end
    check("find_idx2_slot", 32'(found), 32'd1);
    check("pre_reset_an", an, 4'b0100);
    #2 rst = 1'b1;
    #1 check_reset_state("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // shadow cleared: digit 0 shows "0" for a full slot
    exp_q.push_back({4'b0001, 2'd0, 8'hFC});
    drain("after_reset");
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
